dma_controller: RTL and testbench
=================================

// Module: dma_controller
// PURPOSE
// - Burst DMA engine between the external device and the unified memory. CPU pulses cmd when
//   the device raises its ready interrupt; engine requests the bus (BR), waits for grant (BG),
//   copies NUM_LINES lines of LINE_WORDS words from device to memory at DEST_ADDR, then pulses
//   interrupt. Sits beside cpu and Memory and shares the data-memory bus with the CPU.
// PARAMETERS
// - WORD_SIZE      16       bits per word
// - LINE_WORDS     4        words per line (one memory write per line)
// - NUM_LINES      3        lines per transfer (12 words total)
// - DEST_ADDR      16'h01F4 word address of the first destination line
// - WRITE_LATENCY  4        cycles WRITE/addr/data held per line write (memory write latency)
// PORTS
// - CLK        in   1                 clock; all state changes on rising edge
// - reset      in   1                 synchronous, active-high reset
// - cmd        in   1                 CPU start command (1-cycle pulse)
// - BG         in   1                 bus grant from CPU
// - edata      in   LINE_WORDS*WS     line currently presented by external device
// - BR         out  1                 bus request to CPU
// - WRITE      out  1                 memory write strobe
// - addr       out  WORD_SIZE         memory word address
// - data       out  LINE_WORDS*WS     line written to memory
// - offset     out  2                 line index selecting the device's edata (0..NUM_LINES-1)
// - interrupt  out  1                 transfer-complete pulse to CPU
// BEHAVIOUR
// - States: IDLE -> REQ -> XFER -> DONE -> IDLE.
// - Reset (reset=1 at rising edge): state IDLE; BR=0, WRITE=0, interrupt=0, offset=0,
//   line counter=0, latency counter=0; addr and data high-Z. Reset mid-transfer aborts at once.
// - IDLE: cmd=1 -> REQ, BR=1 from the next cycle. cmd ignored in every other state.
// - REQ: BR=1; stay until BG=1, then XFER with line=0, latency counter=0.
// - XFER: BR=1, WRITE=1, offset=line, addr=DEST_ADDR+LINE_WORDS*line (16-bit wrap),
//   data=edata (combinational pass-through). Hold for exactly WRITE_LATENCY cycles per line;
//   then line+1. After line NUM_LINES-1 completes -> DONE.
// - BG drops during XFER: WRITE=0, addr/data high-Z the same cycle, BR stays 1; counters kept
//   except latency counter cleared; current line restarts from its first cycle when BG returns.
// - DONE: one cycle; interrupt=1, BR=0, WRITE=0; then IDLE. interrupt high exactly one cycle.
// - addr/data driven only while WRITE=1; otherwise 'z (shared bus with CPU).
// - offset holds last value outside XFER until reset or next transfer (restarts at 0).
// - Total latency cmd->interrupt with BG granted immediately: 2+NUM_LINES*WRITE_LATENCY cycles.
// STRUCTURE
// - Shared package: WORD_SIZE, LINE_WORDS, DEST_ADDR, state enum {IDLE,REQ,XFER,DONE}.
// - One sub-module natural: dma_line_counter (latency counter + line index, line_done/last).
// - FSM and tri-state output drivers in the top module.
// TESTING
// - cmd pulse, BG one cycle after BR -> writes to 0x01F4,0x01F8,0x01FC, offset 0,1,2, each
//   WRITE held 4 cycles, data==edata; interrupt 1 cycle after last write; BR=0 then.
// - BG held low 10 cycles after cmd -> BR=1, WRITE=0, addr/data 'z throughout; no progress.
// - BG dropped in cycle 2 of line 1 for 3 cycles -> WRITE=0 during gap; line 1 (addr 0x01F8)
//   rewritten for full 4 cycles; total 3 completed lines, single interrupt.
// - cmd pulsed again during XFER -> ignored; exactly 3 lines and one interrupt.
// - reset=1 during line 2 -> next cycle BR=0, WRITE=0, interrupt=0, outputs 'z; new cmd restarts
//   at offset 0, addr 0x01F4.
// - Back-to-back transfers (cmd right after interrupt) -> second transfer identical to first.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// Shared constants, state encoding and address helper for the burst DMA engine.
package dma_controller_pkg;

  localparam int WORD_SIZE     = 16;
  localparam int LINE_WORDS    = 4;
  localparam int NUM_LINES     = 3;
  localparam int WRITE_LATENCY = 4;
  localparam int LINE_W        = 2;
  localparam int LAT_W         = 3;
  localparam int LINE_BITS     = LINE_WORDS * WORD_SIZE;

  localparam logic [WORD_SIZE-1:0] DEST_ADDR = 16'h01F4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } dma_state_e;

  // Word address of a destination line; wraps at 16 bits.
  function automatic logic [WORD_SIZE-1:0] line_addr(input logic [LINE_W-1:0] line);
    logic [WORD_SIZE-1:0] step;
    step = WORD_SIZE'(LINE_WORDS) * WORD_SIZE'(line);
    return DEST_ADDR + step;
  endfunction

endpackage

// File: rtl/dma_line_counter.sv
// Per-line write-latency counter and line index for the DMA transfer.
module dma_line_counter
  import dma_controller_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              clear,
  input  logic              count_en,
  output logic [LINE_W-1:0] line,
  output logic              line_done,
  output logic              last_line
);

  logic [LAT_W-1:0]  lat_r;
  logic [LINE_W-1:0] line_r;

  // Line completion is the final held cycle of a granted write.
  always_comb begin
    last_line = (line_r == LINE_W'(NUM_LINES - 1));
    line_done = count_en && (lat_r == LAT_W'(WRITE_LATENCY - 1));
  end

  // Losing the grant restarts the current line from its first cycle.
  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      lat_r  <= {LAT_W{1'b0}};
      line_r <= {LINE_W{1'b0}};
    end else if (count_en) begin
      if (line_done) begin
        lat_r <= {LAT_W{1'b0}};
        if (!last_line) begin
          line_r <= line_r + LINE_W'(1);
        end else begin
          line_r <= line_r;
        end
      end else begin
        lat_r  <= lat_r + LAT_W'(1);
        line_r <= line_r;
      end
    end else begin
      lat_r  <= {LAT_W{1'b0}};
      line_r <= line_r;
    end
  end

  assign line = line_r;

endmodule

// File: rtl/dma_controller.sv
// Burst DMA engine: copies NUM_LINES device lines into memory at DEST_ADDR over the
// data bus shared with the CPU, using a BR/BG handshake and a completion interrupt.
module dma_controller
  import dma_controller_pkg::*;
(
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 cmd,
  input  logic                 BG,
  input  logic [LINE_BITS-1:0] edata,
  output logic                 BR,
  output logic                 WRITE,
  output logic [WORD_SIZE-1:0] addr,
  output logic [LINE_BITS-1:0] data,
  output logic [1:0]           offset,
  output logic                 interrupt
);

  dma_state_e        state_r;
  logic              br_r;
  logic              irq_r;
  logic              start_s;
  logic              count_en_s;
  logic              line_done_s;
  logic              last_line_s;
  logic [LINE_W-1:0] line_s;

  // The write strobe follows the grant combinationally so the bus is freed the same cycle.
  always_comb begin
    start_s    = (state_r == REQ) && BG;
    count_en_s = (state_r == XFER) && BG;
  end

  dma_line_counter u_line_counter (
    .CLK       (CLK),
    .reset     (reset),
    .clear     (start_s),
    .count_en  (count_en_s),
    .line      (line_s),
    .line_done (line_done_s),
    .last_line (last_line_s)
  );

  // Transfer sequencing with registered bus request and interrupt.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= IDLE;
      br_r    <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          irq_r <= 1'b0;
          if (cmd) begin
            state_r <= REQ;
            br_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
            br_r    <= 1'b0;
          end
        end
        REQ: begin
          br_r  <= 1'b1;
          irq_r <= 1'b0;
          if (BG) begin
            state_r <= XFER;
          end else begin
            state_r <= REQ;
          end
        end
        XFER: begin
          if (line_done_s && last_line_s) begin
            state_r <= DONE;
            br_r    <= 1'b0;
            irq_r   <= 1'b1;
          end else begin
            state_r <= XFER;
            br_r    <= 1'b1;
            irq_r   <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          br_r    <= 1'b0;
          irq_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          br_r    <= 1'b0;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

  assign BR        = br_r;
  assign interrupt = irq_r;
  assign WRITE     = count_en_s;
  assign offset    = line_s;
  assign addr      = count_en_s ? line_addr(line_s) : {WORD_SIZE{1'bz}};
  assign data      = count_en_s ? edata : {LINE_BITS{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: expected line writes are queued per scenario and
// matched against write bursts collected from the bus.
module tb_dma_controller;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  off;
    int          len;
    bit          dok;
  } run_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        cmd = 1'b0;
  logic        BG = 1'b0;
  logic [15:0] seed = 16'h1000;
  logic [63:0] edata;
  logic        BR;
  logic        WRITE;
  wire  [15:0] addr;
  wire  [63:0] data;
  logic [1:0]  offset;
  logic        interrupt;

  int   n_pass = 0;
  int   n_total = 0;
  int   irq_count = 0;
  run_t exp_q[$];
  run_t obs_q[$];

  run_t        cur_run;
  int          run_len = 0;

  dma_controller dut (
    .CLK       (CLK),
    .reset     (reset),
    .cmd       (cmd),
    .BG        (BG),
    .edata     (edata),
    .BR        (BR),
    .WRITE     (WRITE),
    .addr      (addr),
    .data      (data),
    .offset    (offset),
    .interrupt (interrupt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] line_pat(input logic [15:0] s, input logic [1:0] o);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = s + (16'(o) << 4) + 16'(i);
    return r;
  endfunction

  // The device presents the line selected by offset.
  assign edata = line_pat(seed, offset);

  // Bus monitor: collapse consecutive WRITE cycles at one address into a burst record.
  initial begin
    forever begin
      @(negedge CLK);
      if (WRITE === 1'b1) begin
        if (run_len != 0 && addr === cur_run.addr) begin
          run_len = run_len + 1;
        end else begin
          if (run_len != 0) begin
            cur_run.len = run_len;
            obs_q.push_back(cur_run);
          end
          cur_run.addr = addr;
          cur_run.off  = offset;
          cur_run.dok  = 1'b1;
          run_len = 1;
        end
        if (data !== line_pat(seed, offset)) cur_run.dok = 1'b0;
      end else if (run_len != 0) begin
        cur_run.len = run_len;
        obs_q.push_back(cur_run);
        run_len = 0;
      end
      if (interrupt === 1'b1) irq_count = irq_count + 1;
    end
  end

  task automatic push_line(input logic [1:0] off, input int len);
    run_t e;
    e.addr = 16'h01F4 + 16'(off) * 16'd4;
    e.off  = off;
    e.len  = len;
    e.dok  = 1'b1;
    exp_q.push_back(e);
  endtask

  // One transfer: cmd pulse, grant after grant_wait REQ cycles, optional grant gap and
  // optional second cmd; returns at the negedge of the cycle after the interrupt.
  task automatic do_transfer(input int grant_wait, input int drop_start, input int drop_len,
                             input int cmd2_at, output int lat, output logic br_at_irq,
                             output logic irq_after, output int req_bad);
    int n;
    lat = -1;
    br_at_irq = 1'b1;
    req_bad = 0;
    cmd = 1'b1;
    BG = 1'b0;
    @(posedge CLK); #1;
    cmd = 1'b0;
    n = 1;
    while (n < 200) begin
      BG  = (n >= 1 + grant_wait) && !(n >= drop_start && n < drop_start + drop_len);
      cmd = (n == cmd2_at);
      @(negedge CLK);
      if (n <= grant_wait && (BR !== 1'b1 || WRITE !== 1'b0)) req_bad++;
      if (interrupt === 1'b1) begin
        lat = n;
        br_at_irq = BR;
        break;
      end
      @(posedge CLK); #1;
      n++;
    end
    cmd = 1'b0;
    BG = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    irq_after = interrupt;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    n_total++; if (BR !== 1'b0) $display("FAIL reset_br: got %b expected 0", BR); else n_pass++;
    n_total++; if (WRITE !== 1'b0) $display("FAIL reset_write: got %b expected 0", WRITE); else n_pass++;
    n_total++; if (interrupt !== 1'b0) $display("FAIL reset_irq: got %b expected 0", interrupt); else n_pass++;
    n_total++; if (offset !== 2'd0) $display("FAIL reset_offset: got %0d expected 0", offset); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_basic;
    int lat, rb, base;
    logic bri, irqa;
    run_t e, o;
    seed = 16'hA000;
    base = irq_count;
    for (int i = 0; i < 3; i++) push_line(2'(i), 4);
    do_transfer(0, -1, 0, -1, lat, bri, irqa, rb);
    n_total++; if (lat !== 14) $display("FAIL basic_latency: got %0d expected 14", lat); else n_pass++;
    n_total++; if (bri !== 1'b0) $display("FAIL basic_br_at_irq: got %b expected 0", bri); else n_pass++;
    n_total++; if (irqa !== 1'b0) $display("FAIL basic_irq_width: got %b expected 0", irqa); else n_pass++;
    n_total++; if (irq_count - base !== 1) $display("FAIL basic_irq_count: got %0d expected 1", irq_count - base); else n_pass++;
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL basic_lines: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.addr !== e.addr || o.off !== e.off || o.len !== e.len || !o.dok)
        $display("FAIL basic_write: got addr=%h off=%0d len=%0d data_ok=%0d expected addr=%h off=%0d len=%0d data_ok=1", o.addr, o.off, o.len, o.dok, e.addr, e.off, e.len);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bg_wait;
    int lat, rb, base;
    logic bri, irqa;
    run_t e, o;
    seed = 16'hB100;
    base = irq_count;
    for (int i = 0; i < 3; i++) push_line(2'(i), 4);
    do_transfer(10, -1, 0, -1, lat, bri, irqa, rb);
    n_total++; if (rb !== 0) $display("FAIL wait_req_cycles: got %0d bad cycles expected 0", rb); else n_pass++;
    n_total++; if (lat !== 24) $display("FAIL wait_latency: got %0d expected 24", lat); else n_pass++;
    n_total++; if (irq_count - base !== 1) $display("FAIL wait_irq_count: got %0d expected 1", irq_count - base); else n_pass++;
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL wait_lines: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.addr !== e.addr || o.off !== e.off || o.len !== e.len || !o.dok)
        $display("FAIL wait_write: got addr=%h off=%0d len=%0d data_ok=%0d expected addr=%h off=%0d len=%0d data_ok=1", o.addr, o.off, o.len, o.dok, e.addr, e.off, e.len);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bg_drop;
    int lat, rb, base;
    logic bri, irqa;
    run_t e, o;
    seed = 16'hC200;
    base = irq_count;
    push_line(2'd0, 4);
    push_line(2'd1, 1);
    push_line(2'd1, 4);
    push_line(2'd2, 4);
    do_transfer(0, 7, 3, -1, lat, bri, irqa, rb);
    n_total++; if (lat !== 18) $display("FAIL drop_latency: got %0d expected 18", lat); else n_pass++;
    n_total++; if (irq_count - base !== 1) $display("FAIL drop_irq_count: got %0d expected 1", irq_count - base); else n_pass++;
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL drop_bursts: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.addr !== e.addr || o.off !== e.off || o.len !== e.len || !o.dok)
        $display("FAIL drop_write: got addr=%h off=%0d len=%0d data_ok=%0d expected addr=%h off=%0d len=%0d data_ok=1", o.addr, o.off, o.len, o.dok, e.addr, e.off, e.len);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_cmd_again;
    int lat, rb, base;
    logic bri, irqa;
    run_t e, o;
    seed = 16'hD300;
    base = irq_count;
    for (int i = 0; i < 3; i++) push_line(2'(i), 4);
    do_transfer(0, -1, 0, 5, lat, bri, irqa, rb);
    n_total++; if (lat !== 14) $display("FAIL cmd2_latency: got %0d expected 14", lat); else n_pass++;
    repeat (3) @(negedge CLK);
    n_total++; if (irq_count - base !== 1) $display("FAIL cmd2_irq_count: got %0d expected 1", irq_count - base); else n_pass++;
    n_total++; if (BR !== 1'b0) $display("FAIL cmd2_idle_br: got %b expected 0", BR); else n_pass++;
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL cmd2_lines: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.addr !== e.addr || o.off !== e.off || o.len !== e.len || !o.dok)
        $display("FAIL cmd2_write: got addr=%h off=%0d len=%0d data_ok=%0d expected addr=%h off=%0d len=%0d data_ok=1", o.addr, o.off, o.len, o.dok, e.addr, e.off, e.len);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    int lat, rb, base, n;
    logic bri, irqa;
    run_t e, o;
    seed = 16'hE400;
    base = irq_count;
    cmd = 1'b1;
    @(posedge CLK); #1;
    cmd = 1'b0;
    BG = 1'b1;
    n = 1;
    while (n < 11) begin
      @(posedge CLK); #1;
      n++;
    end
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    BG = 1'b0;
    @(negedge CLK);
    n_total++; if (BR !== 1'b0) $display("FAIL rst_mid_br: got %b expected 0", BR); else n_pass++;
    n_total++; if (WRITE !== 1'b0) $display("FAIL rst_mid_write: got %b expected 0", WRITE); else n_pass++;
    n_total++; if (interrupt !== 1'b0) $display("FAIL rst_mid_irq: got %b expected 0", interrupt); else n_pass++;
    n_total++; if (offset !== 2'd0) $display("FAIL rst_mid_offset: got %0d expected 0", offset); else n_pass++;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_total++; if (irq_count - base !== 0) $display("FAIL rst_mid_no_irq: got %0d expected 0", irq_count - base); else n_pass++;
    obs_q.delete();
    for (int i = 0; i < 3; i++) push_line(2'(i), 4);
    do_transfer(0, -1, 0, -1, lat, bri, irqa, rb);
    n_total++; if (lat !== 14) $display("FAIL rst_mid_restart_latency: got %0d expected 14", lat); else n_pass++;
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL rst_mid_lines: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.addr !== e.addr || o.off !== e.off || o.len !== e.len || !o.dok)
        $display("FAIL rst_mid_write: got addr=%h off=%0d len=%0d data_ok=%0d expected addr=%h off=%0d len=%0d data_ok=1", o.addr, o.off, o.len, o.dok, e.addr, e.off, e.len);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, rb, base;
    logic bri, irqa;
    run_t e, o;
    seed = 16'hF500;
    base = irq_count;
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 3; i++) push_line(2'(i), 4);
    do_transfer(0, -1, 0, -1, lat1, bri, irqa, rb);
    do_transfer(0, -1, 0, -1, lat2, bri, irqa, rb);
    n_total++; if (lat1 !== 14) $display("FAIL b2b_latency1: got %0d expected 14", lat1); else n_pass++;
    n_total++; if (lat2 !== 14) $display("FAIL b2b_latency2: got %0d expected 14", lat2); else n_pass++;
    n_total++; if (irqa !== 1'b0) $display("FAIL b2b_irq_width: got %b expected 0", irqa); else n_pass++;
    n_total++; if (irq_count - base !== 2) $display("FAIL b2b_irq_count: got %0d expected 2", irq_count - base); else n_pass++;
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_lines: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++;
      if (o.addr !== e.addr || o.off !== e.off || o.len !== e.len || !o.dok)
        $display("FAIL b2b_write: got addr=%h off=%0d len=%0d data_ok=%0d expected addr=%h off=%0d len=%0d data_ok=1", o.addr, o.off, o.len, o.dok, e.addr, e.off, e.len);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bg_wait();
    test_bg_drop();
    test_cmd_again();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
